seg7_scan_driver: RTL and testbench

//  Parametrised N-digit time-multiplexed 7-segment driver.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment lookup for the 7-segment scan driver.
// Segment patterns are logical (1 = lit) in {a,b,c,d,e,f,g} order.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high abcdefg decoder with a blanking override.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_abcdefg
);

    assign seg_abcdefg = blank ? SEG_BLANK : seg7_hex(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit time-multiplexed 7-segment driver with double-buffered frame data,
// leading-zero blanking, 74x138-style enables and registered pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    en2_n,
    input  logic                    en3_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    upd_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic                  SEG_POL  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                        : {NUM_DIGITS{1'b0}};

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                  pending_q, pending_d;
    logic [DATA_W-1:0]     disp_q, disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  upd_done_q, upd_done_d;

    logic                  tick;
    logic                  commit;
    logic                  act;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  zero_above;
    logic                  blank;
    logic [NUM_DIGITS-1:0] dig_logic;
    logic [6:0]            dec_seg;

    assign act = en & ~en2_n & ~en3_n;

    // Timing, scan and the shadow/display double buffer run regardless of act.
    always_comb begin
        tick        = (div_cnt_q == DIV_LAST);
        commit      = tick && (idx_q == IDX_LAST) && pending_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        shadow_d    = load ? data_in : shadow_q;
        shadow_dp_d = load ? dp_in : shadow_dp_q;
        // A load on the commit edge still marks the new shadow as pending.
        pending_d   = load | (pending_q & ~commit);
        disp_d      = commit ? shadow_q : disp_q;
        disp_dp_d   = commit ? shadow_dp_q : disp_dp_q;
        upd_done_d  = commit;
    end

    // Walk from the top digit down so zero_above covers nibble k and everything above it.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        zero_above = 1'b1;
        blank      = 1'b0;
        dig_logic  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k)) begin
                cur_nib      = disp_q[4*k +: 4];
                cur_dp       = disp_dp_q[k];
                blank        = lzb && (k != 0) && zero_above;
                dig_logic[k] = act;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble      (cur_nib),
        .blank       (blank),
        .seg_abcdefg (dec_seg)
    );

    always_comb begin
        seg_d = (act ? dec_seg : SEG_BLANK) ^ {7{SEG_POL}};
        dp_d  = (act & cur_dp) ^ SEG_POL;
        dig_d = dig_logic ^ DIG_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            seg_q       <= {7{SEG_POL}};
            dp_q        <= SEG_POL;
            dig_q       <= DIG_OFF;
            upd_done_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_q       <= dig_d;
            upd_done_q  <= upd_done_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign dig_sel  = dig_q;
    assign upd_done = upd_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots, active-low pins):
// fixed vector table, hand-written corner sequences, and a cycle-level reference model.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b1;
    logic          en2_n = 1'b0;
    logic          en3_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   data_in = '0;
    logic [3:0]    dp_in = '0;
    logic          lzb = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    dig_sel;
    logic          upd_done;

    int n_cmp = 0;
    int n_fail = 0;

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .TICK_DIV       (TD),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .en2_n    (en2_n),
        .en3_n    (en3_n),
        .load     (load),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .lzb      (lzb),
        .seg      (seg),
        .dp       (dp),
        .dig_sel  (dig_sel),
        .upd_done (upd_done)
    );

    always #5 clk = ~clk;

    // Logical (1 = lit) abcdefg patterns for hex 0..F.
    logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Position in the scan is derived from the number of clock edges since reset.
    int          m_cnt = 0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_shadow_dp = '0;
    logic        m_pending = 1'b0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_disp_dp = '0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_dig = 4'hF;
    logic        e_upd = 1'b0;

    function automatic logic [6:0] model_seg(input int idx, input logic [15:0] disp,
                                             input logic lz, input logic a);
        logic [15:0] upper;
        if (!a) return 7'h7F;
        upper = disp >> (4 * idx);
        if (lz && idx > 0 && upper == 16'h0) return 7'h7F;
        return ~hex_tab[upper[3:0]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int   idx;
        logic tick, a, commit;
        if (!rst_n) begin
            m_cnt = 0; m_shadow = '0; m_shadow_dp = '0; m_pending = 1'b0;
            m_disp = '0; m_disp_dp = '0;
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_upd = 1'b0;
        end else begin
            idx    = (m_cnt / TD) % N;
            tick   = (m_cnt % TD) == TD - 1;
            a      = en && !en2_n && !en3_n;
            e_seg  = model_seg(idx, m_disp, lzb, a);
            e_dp   = a ? ~m_disp_dp[idx] : 1'b1;
            e_dig  = a ? ~(4'b0001 << idx) : 4'hF;
            commit = tick && (idx == N - 1) && m_pending;
            e_upd  = commit;
            if (commit) begin
                m_disp    = m_shadow;
                m_disp_dp = m_shadow_dp;
            end
            m_pending = load || (m_pending && !commit);
            if (load) begin
                m_shadow    = data_in;
                m_shadow_dp = dp_in;
            end
            m_cnt++;
        end
        #1;
        check("monitor", {19'b0, seg, dp, dig_sel, upd_done}, {19'b0, e_seg, e_dp, e_dig, e_upd});
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic        lz;
        logic [3:0]  exp_dig;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vecs[10];

    task automatic load_and_wait(input logic [15:0] d, input logic [3:0] dpv, input logic lz);
        bit seen = 0;
        data_in = d; dp_in = dpv; lzb = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (upd_done) seen = 1;
        end
        check("upd_done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        bit found;
        bit seen2;

        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int k;

        vecs[0] = '{16'h12AF, 4'h0, 1'b0, 4'b1110, 7'b0111000, 1'b1};
        vecs[1] = '{16'h12AF, 4'h0, 1'b0, 4'b0111, 7'b1001111, 1'b1};
        vecs[2] = '{16'h0050, 4'h0, 1'b1, 4'b0111, 7'h7F,      1'b1};
        vecs[3] = '{16'h0050, 4'h0, 1'b1, 4'b1011, 7'h7F,      1'b1};
        vecs[4] = '{16'h0050, 4'h0, 1'b1, 4'b1101, 7'b0100100, 1'b1};
        vecs[5] = '{16'h0050, 4'h0, 1'b1, 4'b1110, 7'b0000001, 1'b1};
        vecs[6] = '{16'h0000, 4'h0, 1'b1, 4'b1110, 7'b0000001, 1'b1};
        vecs[7] = '{16'h0000, 4'h0, 1'b1, 4'b1101, 7'h7F,      1'b1};
        vecs[8] = '{16'h0000, 4'h8, 1'b1, 4'b0111, 7'h7F,      1'b0};
        vecs[9] = '{16'h0000, 4'h0, 1'b0, 4'b1011, 7'b0000001, 1'b1};

        // Test 1: reset values and first tick.
        #1 rst_n = 1'b0;
        #1;
        check("reset_pins", {20'b0, seg, dp, dig_sel}, {20'b0, 7'h7F, 1'b1, 4'hF});
        check("reset_upd", {31'b0, upd_done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("first_tick_dig", {28'b0, dig_sel}, (i <= 4) ? 32'hE : 32'hD);
        end

        // Tests 2 and 3: table of frames and expected digit patterns.
        for (int v = 0; v < 10; v++) begin
            load_and_wait(vecs[v].data, vecs[v].dpv, vecs[v].lz);
            found = 0;
            for (int i = 0; i < 3 * N * TD && !found; i++) begin
                @(negedge clk);
                if (dig_sel == vecs[v].exp_dig) found = 1;
            end
            check("vec_dig_found", {31'b0, found}, 32'd1);
            check("vec_seg_dp", {24'b0, seg, dp}, {24'b0, vecs[v].exp_seg, vecs[v].exp_dp});
        end

        // Test 4: disable mid-frame, scan keeps going, resume at the reached digit.
        load_and_wait(16'h4321, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        en2_n = 1'b1;
        @(negedge clk);
        check("disable_pins", {20'b0, seg, dp, dig_sel}, {20'b0, 7'h7F, 1'b1, 4'hF});
        repeat (5) @(negedge clk);
        en2_n = 1'b0;
        @(negedge clk);
        k = ((m_cnt - 1) / TD) % N;
        check("resume_dig", {28'b0, dig_sel}, {28'b0, ~(4'b0001 << k)});
        check("resume_seg", {25'b0, seg}, {25'b0, ~hex_tab[k + 1]});

        // Test 5: load on the exact commit-tick edge.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_cnt % (N * TD) == 5) found = 1;
        end
        data_in = 16'hAAAA; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_cnt % (N * TD) == N * TD - 1) found = 1;
            else @(negedge clk);
        end
        check("commit_edge_found", {31'b0, found}, 32'd1);
        data_in = 16'h5555; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("commit_upd_first", {31'b0, upd_done}, 32'd1);
        check("commit_old_shadow", {16'b0, m_disp}, 32'h0000AAAA);
        found = 0;
        for (int i = 0; i < 3 * N * TD && !found; i++) begin
            @(negedge clk);
            if (upd_done) found = 1;
        end
        check("commit_upd_second", {31'b0, found}, 32'd1);
        repeat (2) @(negedge clk);
        check("second_value_shown", {25'b0, seg}, {25'b0, ~hex_tab[5]});

        // Random stimulus, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: data_in = 16'($urandom);
                1: data_in = 16'($urandom) & 16'h0FFF;
                2: data_in = 16'($urandom) & 16'h00F0;
                default: data_in = 16'($urandom) & 16'h000F;
            endcase
            dp_in = 4'($urandom_range(0, 15));
            lzb   = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 9) != 0);
            en2_n = ($urandom_range(0, 9) == 0);
            en3_n = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        load = 1'b0; en = 1'b1; en2_n = 1'b0; en3_n = 1'b0;

        // Test 6: asynchronous reset while idx = 2.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if ((m_cnt / TD) % N == 2) found = 1;
        end
        check("idx2_found", {31'b0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pins", {20'b0, seg, dp, dig_sel}, {20'b0, 7'h7F, 1'b1, 4'hF});
        check("async_reset_upd", {31'b0, upd_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_dig", {28'b0, dig_sel}, 32'hE);
        check("restart_seg", {25'b0, seg}, {25'b0, 7'b0000001});
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
